// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types and constants for the ARM-style core.
// Used by fetch_stage and its skid register.
package arm_pipe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } fetch_state_t;

   localparam logic [31:0] BUBBLE_INSTR = 32'h0;
   localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_skid_reg.sv
// Holding register for one fetched instruction and its PC+4.
// Captures a word returned while decode is stalled.
module fetch_skid_reg
   import arm_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] d_instr,
   input  logic [31:0] d_pc4,
   output logic [31:0] q_instr,
   output logic [31:0] q_pc4
);

   logic [63:0] data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data <= '0;
      end else if (clear) begin
         data <= {BUBBLE_INSTR, 32'h0};
      end else if (load) begin
         data <= {d_instr, d_pc4};
      end
   end

   assign q_instr = data[63:32];
   assign q_pc4   = data[31:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, imem handshake and branch flush.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage
   import arm_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
`ifdef FETCH_PERF_CNT_EN
   output logic [CNT_W-1:0] perf_fetch_cnt,
   output logic [CNT_W-1:0] perf_stall_cnt,
`endif
   output logic        ifid_valid
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  tgt;
   logic [31:0]  skid_instr;
   logic [31:0]  skid_pc4;
   logic         in_fetch;
   logic         in_hold;
   logic         skid_load;
   logic         skid_clear;

   assign imem_addr = pc;
   assign pc_next   = pc + PC_STEP;
   assign tgt       = branch_target & ~32'h3;
   assign in_fetch  = (state == FETCH);
   assign in_hold   = (state == HOLD);

   // Capture returned data only when decode refuses it and no redirect.
   assign skid_load  = in_fetch && !branch_taken && imem_ack && stall;
   assign skid_clear = in_hold && branch_taken;

   fetch_skid_reg u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .d_instr (imem_rdata),
      .d_pc4   (pc_next),
      .q_instr (skid_instr),
      .q_pc4   (skid_pc4)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         imem_req   <= 1'b0;
         ifid_instr <= BUBBLE_INSTR;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: begin
               if (branch_taken) begin
                  pc         <= tgt;
                  ifid_valid <= 1'b0;
                  ifid_instr <= BUBBLE_INSTR;
               end else if (imem_ack && !stall) begin
                  ifid_instr <= imem_rdata;
                  ifid_pc4   <= pc_next;
                  ifid_valid <= 1'b1;
                  pc         <= pc_next;
               end else if (imem_ack) begin
                  state    <= HOLD;
                  imem_req <= 1'b0;
               end else if (!stall) begin
                  ifid_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  pc         <= tgt;
                  ifid_valid <= 1'b0;
                  ifid_instr <= BUBBLE_INSTR;
                  state      <= FETCH;
                  imem_req   <= 1'b1;
               end else if (!stall) begin
                  ifid_instr <= skid_instr;
                  ifid_pc4   <= skid_pc4;
                  ifid_valid <= 1'b1;
                  pc         <= pc_next;
                  state      <= FETCH;
                  imem_req   <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_inc;

   assign fetch_inc = !branch_taken && !stall &&
                      ((in_fetch && imem_ack) || in_hold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch_inc && !(&perf_fetch_cnt)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
         end
         if (stall && !(&perf_stall_cnt)) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// ROM model returns word index (addr>>2) as the instruction.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   int errors;
   int checks;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ack      (imem_ack),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata = imem_addr >> 2;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      reset         = 1'b1;
      imem_ack      = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      repeat (2) tick();

      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(ifid_valid), 32'd0);
      check("rst_instr", ifid_instr, 32'h0);
      check("rst_pc4", ifid_pc4, 32'h0);

      // IDLE for one cycle, then FETCH
      reset = 1'b0;
      tick();
      check("idle_req", 32'(imem_req), 32'd1);
      check("idle_addr", imem_addr, 32'h0);

      // zero-wait streaming
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("zw_valid", 32'(ifid_valid), 32'd1);
         check("zw_instr", ifid_instr, 32'(i));
         check("zw_pc4", ifid_pc4, 32'(4 * i + 4));
         check("zw_addr", imem_addr, 32'(4 * i + 4));
      end

      // stall 4 cycles on ack at pc=12 -> word 3 goes to skid
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("st_req", 32'(imem_req), 32'd0);
         check("st_instr", ifid_instr, 32'd2);
         check("st_valid", 32'(ifid_valid), 32'd1);
         check("st_pc4", ifid_pc4, 32'd12);
      end
      stall = 1'b0;
      tick();
      check("rel_instr", ifid_instr, 32'd3);
      check("rel_pc4", ifid_pc4, 32'd16);
      check("rel_req", 32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, 32'd16);
      tick();
      check("rel_next", ifid_instr, 32'd4);
      check("rel_next_pc4", ifid_pc4, 32'd20);

      // branch with ack: data dropped, target aligned
      branch_taken  = 1'b1;
      branch_target = 32'h103;
      tick();
      check("br_valid", 32'(ifid_valid), 32'd0);
      check("br_instr", ifid_instr, 32'h0);
      check("br_addr", imem_addr, 32'h100);

      // redirect to 0 with no ack, then 3 wait cycles
      branch_target = 32'h0;
      imem_ack      = 1'b0;
      tick();
      branch_taken = 1'b0;
      check("br0_addr", imem_addr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("w_req", 32'(imem_req), 32'd1);
         check("w_addr", imem_addr, 32'h0);
         check("w_valid", 32'(ifid_valid), 32'd0);
      end
      imem_ack = 1'b1;
      tick();
      check("w_done_valid", 32'(ifid_valid), 32'd1);
      check("w_done_instr", ifid_instr, 32'd0);
      check("w_done_pc4", ifid_pc4, 32'd4);

      // stall into HOLD, then branch+stall in HOLD
      stall = 1'b1;
      tick();
      check("h_req", 32'(imem_req), 32'd0);
      imem_ack      = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      tick();
      branch_taken = 1'b0;
      check("hb_valid", 32'(ifid_valid), 32'd0);
      check("hb_instr", ifid_instr, 32'h0);
      check("hb_req", 32'(imem_req), 32'd1);
      check("hb_addr", imem_addr, 32'h40);
      stall    = 1'b0;
      imem_ack = 1'b1;
      tick();
      check("hb_resume", ifid_instr, 32'h10);
      check("hb_resume_pc4", ifid_pc4, 32'h44);

      // flush and stall together in FETCH: flush wins, stays FETCH
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      tick();
      branch_taken = 1'b0;
      stall        = 1'b0;
      check("fs_valid", 32'(ifid_valid), 32'd0);
      check("fs_req", 32'(imem_req), 32'd1);
      check("fs_addr", imem_addr, 32'hFFFF_FFFC);

      // PC wrap
      tick();
      check("wrap_instr", ifid_instr, 32'h3FFF_FFFF);
      check("wrap_pc4", ifid_pc4, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // reset mid-wait
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      tick();
      branch_taken = 1'b0;
      imem_ack     = 1'b0;
      tick();
      check("mw_req", 32'(imem_req), 32'd1);
      check("mw_addr", imem_addr, 32'h200);
      #2;
      reset = 1'b1;
      #1;
      check("ar_req", 32'(imem_req), 32'd0);
      check("ar_valid", 32'(ifid_valid), 32'd0);
      check("ar_instr", ifid_instr, 32'h0);
      check("ar_pc4", ifid_pc4, 32'h0);
      check("ar_addr", imem_addr, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      check("rr_req", 32'(imem_req), 32'd1);
      check("rr_addr", imem_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
